// File: rtl/stack_memory_pkg.sv
// ============================================================================
//  Module      : stack_memory_pkg
//  Description : Processor-wide constants shared by the stack storage block.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package stack_memory_pkg;

    localparam int WORD_W      = 32;
    localparam int STACK_DEPTH = 256;

    // Full-width compare so pointers beyond the array never alias back in.
    function automatic logic sp_in_range(input logic [WORD_W-1:0] sp, input int depth);
        logic [WORD_W-1:0] lim;
        lim = depth[WORD_W-1:0];
        return (sp < lim);
    endfunction

endpackage

`default_nettype wire

// File: rtl/stack_memory.sv
// ============================================================================
//  Module      : stack_memory
//  Description : Word-addressed stack RAM with registered read port and
//                combinational out-of-range flag.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module stack_memory
    import stack_memory_pkg::*;
#(
    parameter int DEPTH  = STACK_DEPTH,
    parameter int ADDR_W = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic [WORD_W-1:0] stack_pointer,
    input  logic              pop,
    input  logic [WORD_W-1:0] data_in,
    input  logic              push,
    output logic [WORD_W-1:0] data_out,
    output logic              sp_error
);

    // No reset on the array so it maps onto block RAM.
    logic [WORD_W-1:0] r_mem [DEPTH] = '{default: '0};
    logic [WORD_W-1:0] r_data_out;

    logic              w_in_range;
    logic [ADDR_W-1:0] w_addr;
    logic              w_wr_en;
    logic              w_rd_en;

    assign w_in_range = sp_in_range(stack_pointer, DEPTH);
    assign w_addr     = stack_pointer[ADDR_W-1:0];
    assign w_wr_en    = reset_n & push & w_in_range;
    assign w_rd_en    = pop & w_in_range;

    assign sp_error   = (push | pop) & ~w_in_range;
    assign data_out   = r_data_out;

    always_ff @(posedge clk) begin
        if (w_wr_en) begin
            r_mem[w_addr] <= data_in;
        end
    end

    // Read-before-write: a same-cycle pop sees the pre-push contents.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_data_out <= '0;
        end else if (w_rd_en) begin
            r_data_out <= r_mem[w_addr];
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_stack_memory.sv
// ============================================================================
//  Module      : tb_stack_memory
//  Description : Directed self-checking bench for stack_memory.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_stack_memory;

    logic        clk = 1'b0;
    logic        reset_n;
    logic [31:0] stack_pointer;
    logic        pop;
    logic [31:0] data_in;
    logic        push;
    logic [31:0] data_out;
    logic        sp_error;

    int          n_vec = 0;
    int          n_err = 0;

    logic [31:0] model_mem [256];
    logic [31:0] model_dout;
    logic [31:0] exp_q [$];

    always #5 clk = ~clk;

    stack_memory dut (
        .clk           (clk),
        .reset_n       (reset_n),
        .stack_pointer (stack_pointer),
        .pop           (pop),
        .data_in       (data_in),
        .push          (push),
        .data_out      (data_out),
        .sp_error      (sp_error)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        assert (got === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, got, exp);
        end
    endtask

    // Drive one cycle of stimulus, queue the model's expected data_out,
    // then compare after the capturing edge.
    task automatic op(input logic rn, input logic ps, input logic pp,
                      input logic [31:0] sp, input logic [31:0] d);
        logic        err;
        logic [31:0] e;
        reset_n       = rn;
        push          = ps;
        pop           = pp;
        stack_pointer = sp;
        data_in       = d;
        #1;
        err = (ps | pp) && (sp >= 32'd256);
        check("sp_error", {31'b0, sp_error}, {31'b0, err});
        e = model_dout;
        if (!rn) begin
            e = '0;
        end else if (!err) begin
            if (pp) e = model_mem[sp[7:0]];
            if (ps) model_mem[sp[7:0]] = d;
        end
        model_dout = e;
        exp_q.push_back(e);
        @(posedge clk);
        #1;
        check("data_out", data_out, exp_q.pop_front());
    endtask

    initial begin
        for (int i = 0; i < 256; i++) model_mem[i] = '0;
        model_dout = '0;

        // Reset with pop asserted
        op(1'b0, 1'b0, 1'b1, 32'd0, 32'h0);
        op(1'b0, 1'b0, 1'b1, 32'd0, 32'h0);
        check("reset_dout", data_out, 32'h0);

        // Push then pop at SP=0
        op(1'b1, 1'b1, 1'b0, 32'd0, 32'hdeadbeef);
        op(1'b1, 1'b0, 1'b1, 32'd0, 32'h0);
        check("pop_sp0", data_out, 32'hdeadbeef);

        // Multiple locations
        op(1'b1, 1'b1, 1'b0, 32'd0, 32'h11111111);
        op(1'b1, 1'b1, 1'b0, 32'd1, 32'h22222222);
        op(1'b1, 1'b1, 1'b0, 32'd2, 32'h33333333);
        op(1'b1, 1'b0, 1'b1, 32'd2, 32'h0);
        check("pop_sp2", data_out, 32'h33333333);
        op(1'b1, 1'b0, 1'b1, 32'd1, 32'h0);
        check("pop_sp1", data_out, 32'h22222222);
        op(1'b1, 1'b0, 1'b1, 32'd0, 32'h0);
        check("pop_sp0b", data_out, 32'h11111111);

        // Simultaneous push/pop: read-before-write
        op(1'b1, 1'b1, 1'b0, 32'd5, 32'hAAAA0000);
        op(1'b1, 1'b1, 1'b1, 32'd5, 32'h5555FFFF);
        check("rbw_old", data_out, 32'hAAAA0000);
        op(1'b1, 1'b0, 1'b1, 32'd5, 32'h0);
        check("rbw_new", data_out, 32'h5555FFFF);

        // Out of range
        op(1'b1, 1'b1, 1'b0, 32'd256, 32'hBEEFCAFE);
        op(1'b1, 1'b0, 1'b1, 32'hFFFFFFFF, 32'h0);
        check("oor_hold", data_out, 32'h5555FFFF);
        op(1'b1, 1'b0, 1'b1, 32'd0, 32'h0);
        check("oor_nowrite", data_out, 32'h11111111);

        // Top in-range index
        op(1'b1, 1'b1, 1'b0, 32'd255, 32'h0BADF00D);
        op(1'b1, 1'b0, 1'b1, 32'd255, 32'h0);
        check("pop_sp255", data_out, 32'h0BADF00D);

        // Idle hold
        for (int i = 0; i < 5; i++) begin
            op(1'b1, 1'b0, 1'b0, 32'd1, 32'hFFFFFFFF);
            check("idle_hold", data_out, 32'h0BADF00D);
        end

        // Reset retention
        op(1'b0, 1'b1, 1'b0, 32'd0, 32'h77777777);
        check("reset_clr", data_out, 32'h0);
        op(1'b1, 1'b0, 1'b1, 32'd0, 32'h0);
        check("retain_sp0", data_out, 32'h11111111);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

`default_nettype wire
